// File: rtl/mem_arbiter_v1_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic                  wren;
    logic [DEF_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_v1_if.sv
// Request/response ports of both requesters plus the single-port memory connection.
interface mem_arbiter_v1_if #(
  parameter int ADDR_W = mem_pkg::DEF_ADDR_W,
  parameter int DATA_W = mem_pkg::DEF_DATA_W
);

  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic              req0_wren;
  logic [DATA_W-1:0] req0_wdata;
  logic              resp0_valid;
  logic [DATA_W-1:0] resp0_rdata;

  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic              req1_wren;
  logic [DATA_W-1:0] req1_wdata;
  logic              resp1_valid;
  logic [DATA_W-1:0] resp1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0_valid, req0_addr, req0_wren, req0_wdata,
    input  req1_valid, req1_addr, req1_wren, req1_wdata,
    input  mem_rdata,
    output req0_ready, resp0_valid, resp0_rdata,
    output req1_ready, resp1_valid, resp1_rdata,
    output mem_addr, mem_wren, mem_wdata
  );

  modport master (
    output req0_valid, req0_addr, req0_wren, req0_wdata,
    output req1_valid, req1_addr, req1_wren, req1_wdata,
    output mem_rdata,
    input  req0_ready, resp0_valid, resp0_rdata,
    input  req1_ready, resp1_valid, resp1_rdata,
    input  mem_addr, mem_wren, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_v1_rr_arbiter2.sv
// Two-way round-robin grant: on contention the port not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    if (&valid_i) begin
      grant_o = last_i ? 2'b01 : 2'b10;
    end else begin
      grant_o = valid_i;
    end
  end

endmodule

// File: rtl/mem_arbiter_v1.sv
// Serialises two requesters onto one single-port memory, one transaction at a time:
// accept -> ACCESS -> WAIT (MEM_LAT cycles) -> RESP -> IDLE.
module mem_arbiter_v1
  import mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  mem_arbiter_v1_if.slave bus
);

  localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

  arb_state_t        state_q, state_d;
  logic              port_q, port_d;  // granted port; doubles as last-grant for round robin
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wren_q, wren_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        grant;
  logic [1:0]        ready;
  logic [1:0]        resp_v;

  rr_arbiter2 u_rr (
    .valid_i ({bus.req1_valid, bus.req0_valid}),
    .last_i  (port_q),
    .grant_o (grant)
  );

  // Ready is masked while reset is held so nothing is offered during reset.
  assign ready = (rst && state_q == IDLE) ? grant : 2'b00;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d = state_q;
    port_d  = port_q;
    addr_d  = addr_q;
    wren_d  = wren_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|ready) begin
          state_d = ACCESS;
          port_d  = ready[1];
          addr_d  = ready[1] ? bus.req1_addr  : bus.req0_addr;
          wren_d  = ready[1] ? bus.req1_wren  : bus.req0_wren;
          wdata_d = ready[1] ? bus.req1_wdata : bus.req0_wdata;
        end
      end
      ACCESS: begin
        state_d = WAIT;
        cnt_d   = 2'd0;
      end
      WAIT: begin
        if (cnt_q == LAT_LAST) begin
          state_d = RESP;
          data_d  = wren_q ? '0 : bus.mem_rdata;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      port_q  <= 1'b1;
      addr_q  <= '0;
      wren_q  <= 1'b0;
      wdata_q <= '0;
      data_q  <= '0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      addr_q  <= addr_d;
      wren_q  <= wren_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign resp_v = (state_q == RESP) ? {port_q, ~port_q} : 2'b00;

  assign bus.req0_ready  = ready[0];
  assign bus.req1_ready  = ready[1];
  assign bus.resp0_valid = resp_v[0];
  assign bus.resp1_valid = resp_v[1];
  assign bus.resp0_rdata = resp_v[0] ? data_q : '0;
  assign bus.resp1_rdata = resp_v[1] ? data_q : '0;

  assign bus.mem_wren  = (state_q == ACCESS) && wren_q;
  assign bus.mem_addr  = (state_q == ACCESS || state_q == WAIT) ? addr_q : '0;
  assign bus.mem_wdata = (state_q == ACCESS) ? wdata_q : '0;

endmodule
